// File: rtl/feature_window_streamer.sv
// feature_window_streamer
// Streaming wrapper around the HDC sensor-fusion core. The front end turns a
// stream of single feature entries into a 3-deep sliding window
// {cur, prev1, prev2}; the back end buffers the core's valence/arousal result
// and tags it "warm" when its window held three real entries. A credit counter
// bounds the number of entries in flight between the two ends.

`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 4
`endif

module feature_window_streamer #(
    parameter int FEAT_W       = `TOTAL_NUM_CHANNEL * `CHANNEL_WIDTH,
    parameter int MAX_INFLIGHT = 4,   // power of two, >= 2
    parameter int CNT_W        = 16,
    localparam int PTR_W       = $clog2(MAX_INFLIGHT),
    localparam int OUT_W       = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst,          // asynchronous, active low
    input  logic                  clear,        // synchronous session restart

    // Upstream feature stream
    input  logic [FEAT_W-1:0]     s_feature,
    input  logic                  s_valid,
    output logic                  s_ready,

    // Window to the core
    output logic [3*FEAT_W-1:0]   features_top,
    output logic                  fin_valid,
    input  logic                  fin_ready,

    // Result from the core
    input  logic                  valence,
    input  logic                  arousal,
    input  logic                  dout_valid,
    output logic                  dout_ready,

    // Downstream result stream
    output logic                  m_valence,
    output logic                  m_arousal,
    output logic                  m_warm,
    output logic                  m_valid,
    input  logic                  m_ready,

    // Statistics and status
    output logic [CNT_W-1:0]      entries_sent,
    output logic [CNT_W-1:0]      results_rcvd,
    output logic [OUT_W-1:0]      outstanding,
    output logic                  err
);

    // ------------------------------------------------------------------
    // Session history: the two most recently accepted entries and how many
    // of those slots hold real data (saturates at 2).
    // ------------------------------------------------------------------
    logic [FEAT_W-1:0] hist1;
    logic [FEAT_W-1:0] hist2;
    logic [1:0]        fill_cnt;

    // Warm-tag FIFO. Its occupancy always equals outstanding, so it needs
    // no count of its own and can never overflow or be popped when empty.
    logic [MAX_INFLIGHT-1:0] tag_mem;
    logic [PTR_W-1:0]        tag_wr_ptr;
    logic [PTR_W-1:0]        tag_rd_ptr;

    // Handshake qualifiers
    logic has_credit;
    logic accept;
    logic fin_hs;
    logic res_hs;
    logic res_ok;
    logic res_bad;

    // History as seen by an entry accepted this cycle; a same-cycle clear
    // makes the new entry start a fresh session.
    logic [FEAT_W-1:0] win_h1;
    logic [FEAT_W-1:0] win_h2;
    logic [1:0]        win_fill;
    logic              win_warm;

    // Credit check uses the registered count only: a result returning this
    // cycle frees its slot from the next cycle on.
    assign has_credit = (outstanding < OUT_W'(MAX_INFLIGHT));
    assign s_ready    = (~fin_valid | fin_ready) & has_credit;
    assign dout_ready = ~m_valid | m_ready;

    assign accept  = s_valid & s_ready;
    assign fin_hs  = fin_valid & fin_ready;
    assign res_hs  = dout_valid & dout_ready;
    assign res_ok  = res_hs & (outstanding != '0);
    assign res_bad = res_hs & (outstanding == '0);

    assign win_h1   = clear ? '0 : hist1;
    assign win_h2   = clear ? '0 : hist2;
    assign win_fill = clear ? 2'd0 : fill_cnt;
    assign win_warm = (win_fill == 2'd2);

    // Window register and its valid toward the core
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            features_top <= '0;
            fin_valid    <= 1'b0;
        end else begin
            // NOTE: all clocked state uses non-blocking assignment so every
            // register samples pre-edge values regardless of block order.
            if (accept) begin
                features_top <= {s_feature, win_h1, win_h2};
                fin_valid    <= 1'b1;
            end else if (fin_ready) begin
                fin_valid    <= 1'b0;
            end
        end
    end

    // Sliding history and fill level; clear restarts the session
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist1    <= '0;
            hist2    <= '0;
            fill_cnt <= 2'd0;
        end else if (accept) begin
            hist1    <= s_feature;
            hist2    <= win_h1;
            fill_cnt <= (win_fill == 2'd2) ? 2'd2 : win_fill + 2'd1;
        end else if (clear) begin
            hist1    <= '0;
            hist2    <= '0;
            fill_cnt <= 2'd0;
        end
    end

    // Tag FIFO storage, written on every accept
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; the pointers
        // below define which slots are valid, so stale contents are never read.
        if (accept) begin
            tag_mem[tag_wr_ptr] <= win_warm;
        end
    end

    // Tag FIFO pointers; pointer wrap is free because depth is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_wr_ptr <= '0;
            tag_rd_ptr <= '0;
        end else begin
            if (accept) begin
                tag_wr_ptr <= tag_wr_ptr + 1'b1;
            end
            if (res_ok) begin
                tag_rd_ptr <= tag_rd_ptr + 1'b1;
            end
        end
    end

    // Credit counter: +1 per accepted entry, -1 per expected result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            unique case ({accept, res_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Downstream result buffer; an unexpected result is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid   <= 1'b0;
            m_valence <= 1'b0;
            m_arousal <= 1'b0;
            m_warm    <= 1'b0;
        end else if (res_ok) begin
            m_valid   <= 1'b1;
            m_valence <= valence;
            m_arousal <= arousal;
            m_warm    <= tag_mem[tag_rd_ptr];
        end else if (m_ready) begin
            m_valid   <= 1'b0;
        end
    end

    // Statistics counters; clear has priority over a same-cycle handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            entries_sent <= '0;
            results_rcvd <= '0;
        end else if (clear) begin
            entries_sent <= '0;
            results_rcvd <= '0;
        end else begin
            if (fin_hs) begin
                entries_sent <= entries_sent + 1'b1;
            end
            if (res_ok) begin
                results_rcvd <= results_rcvd + 1'b1;
            end
        end
    end

    // Sticky protocol error: a result arrived with nothing in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err <= 1'b0;
        end else if (res_bad) begin
            err <= 1'b1;
        end
    end

endmodule
